// File: rtl/sparse_scan_scheduler.sv
// sparse_scan_scheduler
//   Sequences the sparse-term controller across every sparse-memory entry of
//   one polymult: presents an address, pulses ctrl_start_o, waits for the
//   controller busy window to open and close, then advances to the next entry.
//
//   Optional feature macro: DUMMY_INSERT_EN
//     defined   - always issues MEM_SPARSE_SIZE operations; entries at or past
//                 the clamped valid count run with dummy_o=1, giving a run
//                 length independent of num_valid_i.
//     undefined - issues only the clamped valid count; dummy_o tied to 0.
//
//   Ports
//     clk, rst_n          clock (rising edge), asynchronous active-low reset
//     start_i             run request, sampled only when idle
//     num_valid_i         real sparse entries, latched (clamped) on accepted start
//     sparse_mem_addr_o   sparse-memory read address (zero-extended index)
//     ctrl_start_o        one-cycle controller start pulse
//     ctrl_busy_i         controller busy flag
//     dummy_o             current operation is a dummy
//     busy_o              run in progress
//     done_o              one-cycle end-of-run pulse (normal or error)
//     error_o             sticky controller timeout, cleared by next accepted start
//     issued_count_o      operations completed in the current/last run
module sparse_scan_scheduler #(
   parameter int MEM_SPARSE_SIZE = 50,
   parameter int ADDR_WIDTH      = 10,
   parameter int CNT_WIDTH       = 6,
   parameter int TIMEOUT_CYCLES  = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   input  logic [CNT_WIDTH-1:0]  num_valid_i,
   output logic [ADDR_WIDTH-1:0] sparse_mem_addr_o,
   output logic                  ctrl_start_o,
   input  logic                  ctrl_busy_i,
   output logic                  dummy_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  error_o,
   output logic [CNT_WIDTH-1:0]  issued_count_o
);

   localparam int                   TO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_WIDTH-1:0] MAX_N   = CNT_WIDTH'(MEM_SPARSE_SIZE);
   localparam logic [TO_W-1:0]      TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE, S_ADVANCE, S_FINISH, S_ERROR
   } state_t;

   state_t               state, state_nxt;
   logic [CNT_WIDTH-1:0] idx, nv, nv_in, total, total_in, idx_inc;
   logic [TO_W-1:0]      tcnt;
   logic                 timed_out;

   assign nv_in     = (num_valid_i > MAX_N) ? MAX_N : num_valid_i;
   assign idx_inc   = idx + 1'b1;
   assign timed_out = (tcnt == TO_LAST);

`ifdef DUMMY_INSERT_EN
   assign total    = MAX_N;
   assign total_in = MAX_N;
`else
   assign total    = nv;
   assign total_in = nv_in;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      ctrl_start_o = 1'b0;
      done_o       = 1'b0;
      case (state)
         S_IDLE:      if (start_i) state_nxt = (total_in == '0) ? S_FINISH : S_ISSUE;
         S_ISSUE: begin
            ctrl_start_o = 1'b1;
            state_nxt    = S_WAIT_ACK;
         end
         S_WAIT_ACK: begin
            if (ctrl_busy_i)    state_nxt = S_WAIT_DONE;
            else if (timed_out) state_nxt = S_ERROR;
         end
         S_WAIT_DONE: begin
            if (!ctrl_busy_i)   state_nxt = S_ADVANCE;
            else if (timed_out) state_nxt = S_ERROR;
         end
         S_ADVANCE:   state_nxt = (idx_inc == total) ? S_FINISH : S_ISSUE;
         S_FINISH: begin
            done_o    = 1'b1;
            state_nxt = S_IDLE;
         end
         S_ERROR: begin
            done_o    = 1'b1;
            state_nxt = S_IDLE;
         end
         default:     state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx               <= '0;
         nv                <= '0;
         tcnt              <= '0;
         busy_o            <= 1'b0;
         error_o           <= 1'b0;
         issued_count_o    <= '0;
         sparse_mem_addr_o <= '0;
      end else begin
         case (state)
            S_IDLE: if (start_i) begin
               busy_o            <= 1'b1;
               error_o           <= 1'b0;
               issued_count_o    <= '0;
               idx               <= '0;
               nv                <= nv_in;
               sparse_mem_addr_o <= '0;
               tcnt              <= '0;
            end
            S_ISSUE:     tcnt <= '0;
            // A busy sighting restarts the count for the WAIT_DONE window.
            S_WAIT_ACK:  tcnt <= ctrl_busy_i ? '0 : tcnt + 1'b1;
            S_WAIT_DONE: tcnt <= tcnt + 1'b1;
            S_ADVANCE: begin
               issued_count_o <= idx_inc;
               tcnt           <= '0;
               if (idx_inc != total) begin
                  idx               <= idx_inc;
                  sparse_mem_addr_o <= ADDR_WIDTH'(idx_inc);
               end
            end
            S_FINISH:    busy_o <= 1'b0;
            S_ERROR: begin
               busy_o  <= 1'b0;
               error_o <= 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef DUMMY_INSERT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                   dummy_o <= 1'b0;
      else if (state == S_ISSUE)                    dummy_o <= (idx >= nv);
      else if (state == S_FINISH || state == S_ERROR) dummy_o <= 1'b0;
   end
`else
   assign dummy_o = 1'b0;
`endif

endmodule
